// File: rtl/clint_arbiter_pkg.sv
// Shared master IDs and CLINT register map for the CLINT port arbiter.
package clint_arbiter_pkg;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  localparam logic [31:0] MSIP_BASE     = 32'h0000_0000;
  localparam logic [31:0] MTIMECMP_BASE = 32'h0000_0010;
  localparam logic [31:0] MTIME_BASE    = 32'h0000_0018;

  function automatic logic [1:0] id2gnt(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/clint_arbiter_arb_rr2.sv
// Two-way grant cell: combinational grant, last-winner pointer and lock-run counter.
// The lock inputs are only driven by the top when CLINT_ARB_LOCK_EN is defined.
module clint_arbiter_arb_rr2
  import clint_arbiter_pkg::*;
#(
  parameter bit PRIO_M0  = 1'b0,
  parameter int LOCK_MAX = 4
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  input  logic       accept,
  output logic [1:0] gnt
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);

  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          win;

  always_comb begin
    win = ARB_M0;
    if (req == 2'b10) begin
      win = ARB_M1;
    end else if (req == 2'b11) begin
      // A locked holder keeps the port until its run is used up, then yields once.
      if (lock[last_q]) win = (cnt_q < LMAX) ? last_q : ~last_q;
      else              win = PRIO_M0 ? ARB_M0 : ~last_q;
    end
    gnt = (req == 2'b00) ? 2'b00 : id2gnt(win);
  end

  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    if (!lock[last_q]) cnt_d = '0;
    if (accept && (req != 2'b00)) begin
      last_d = win;
      if (!lock[win])          cnt_d = '0;
      else if (win != last_q)  cnt_d = CW'(1);
      else if (cnt_q < LMAX)   cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      last_q <= ARB_M1;
      cnt_q  <= '0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/clint_arbiter.sv
// Arbitrates the CLINT write and read channels between the core (m0) and debug/DMA (m1).
// Define CLINT_ARB_LOCK_EN to add m*_lock inputs for atomic multi-beat accesses.
module clint_arbiter
  import clint_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter bit PRIO_M0  = 1'b0,
  parameter int LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          resetb,
`ifdef CLINT_ARB_LOCK_EN
  input  logic          m0_lock,
  input  logic          m1_lock,
`endif
  input  logic          m0_wready,
  output logic          m0_wvalid,
  input  logic [AW-1:0] m0_waddr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [3:0]    m0_wstrb,
  input  logic          m0_rready,
  output logic          m0_rvalid,
  input  logic [AW-1:0] m0_raddr,
  output logic          m0_rresp,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_wready,
  output logic          m1_wvalid,
  input  logic [AW-1:0] m1_waddr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [3:0]    m1_wstrb,
  input  logic          m1_rready,
  output logic          m1_rvalid,
  input  logic [AW-1:0] m1_raddr,
  output logic          m1_rresp,
  output logic [DW-1:0] m1_rdata,
  output logic          s_wready,
  output logic [AW-1:0] s_waddr,
  output logic [DW-1:0] s_wdata,
  output logic [3:0]    s_wstrb,
  input  logic          s_wvalid,
  output logic          s_rready,
  output logic [AW-1:0] s_raddr,
  input  logic          s_rvalid,
  input  logic          s_rresp,
  input  logic [DW-1:0] s_rdata
);

  logic [1:0] wreq, rreq, wgnt, rgnt, lock;
  logic       w_win, r_win, rd_acc;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_owner_q, rd_owner_d;

`ifdef CLINT_ARB_LOCK_EN
  assign lock = {m1_lock, m0_lock};
`else
  assign lock = 2'b00;
`endif

  assign wreq = {m1_wready, m0_wready};
  assign rreq = {m1_rready, m0_rready};

  clint_arbiter_arb_rr2 #(.PRIO_M0(PRIO_M0), .LOCK_MAX(LOCK_MAX)) u_warb (
    .clk(clk), .resetb(resetb), .req(wreq), .lock(lock), .accept(s_wvalid), .gnt(wgnt)
  );

  clint_arbiter_arb_rr2 #(.PRIO_M0(PRIO_M0), .LOCK_MAX(LOCK_MAX)) u_rarb (
    .clk(clk), .resetb(resetb), .req(rreq), .lock(lock), .accept(s_rvalid), .gnt(rgnt)
  );

  assign w_win    = wgnt[1];
  assign r_win    = rgnt[1];

  assign s_wready = |wreq;
  assign s_waddr  = w_win ? m1_waddr : m0_waddr;
  assign s_wdata  = w_win ? m1_wdata : m0_wdata;
  assign s_wstrb  = w_win ? m1_wstrb : m0_wstrb;
  assign s_rready = |rreq;
  assign s_raddr  = r_win ? m1_raddr : m0_raddr;

  assign m0_wvalid = wgnt[0] & s_wvalid;
  assign m1_wvalid = wgnt[1] & s_wvalid;
  assign m0_rvalid = rgnt[0] & s_rvalid;
  assign m1_rvalid = rgnt[1] & s_rvalid;

  // Owner is recaptured on every accept so back-to-back reads pipeline with latency 1.
  assign rd_acc = s_rready & s_rvalid;

  always_comb begin
    rd_pend_d  = rd_acc;
    rd_owner_d = rd_owner_q;
    if (rd_acc) rd_owner_d = r_win;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= ARB_M0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign m0_rresp = s_rresp & rd_pend_q & (rd_owner_q == ARB_M0);
  assign m1_rresp = s_rresp & rd_pend_q & (rd_owner_q == ARB_M1);
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_clint_arbiter.sv
// Scoreboard bench for clint_arbiter: round-robin instance (a_) and strict-priority instance (b_).
module tb_clint_arbiter;
  import clint_arbiter_pkg::*;

  localparam logic [31:0] MTIME_LO  = 32'h1234_5678;
  localparam logic [31:0] MSIP_WORD = 32'h0000_0002;

  typedef struct {logic id; logic [31:0] addr; logic [31:0] data; logic [3:0] strb;} wexp_t;
  typedef struct {logic id; logic [31:0] data;} rexp_t;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  logic        m0_lock = 0, m1_lock = 0;
  logic        m0_wready = 0, m1_wready = 0, m0_rready = 0, m1_rready = 0;
  logic [31:0] m0_waddr = 0, m1_waddr = 0, m0_wdata = 0, m1_wdata = 0;
  logic [31:0] m0_raddr = 0, m1_raddr = 0;
  logic [3:0]  m0_wstrb = 4'hF, m1_wstrb = 4'h3;
  logic        s_wvalid = 1'b1, s_rvalid = 1'b1;
  logic        s_rresp = 1'b0;
  logic [31:0] s_rdata = '0;

  logic        a_m0_wvalid, a_m1_wvalid, a_m0_rvalid, a_m1_rvalid, a_m0_rresp, a_m1_rresp;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_s_waddr, a_s_wdata, a_s_raddr;
  logic [3:0]  a_s_wstrb;
  logic        a_s_wready, a_s_rready;
  logic        b_m0_wvalid, b_m1_wvalid, b_m0_rvalid, b_m1_rvalid, b_m0_rresp, b_m1_rresp;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_s_waddr, b_s_wdata, b_s_raddr;
  logic [3:0]  b_s_wstrb;
  logic        b_s_wready, b_s_rready;

  clint_arbiter #(.PRIO_M0(1'b0)) dut_a (
    .clk(clk), .resetb(resetb),
`ifdef CLINT_ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .m0_wready(m0_wready), .m0_wvalid(a_m0_wvalid), .m0_waddr(m0_waddr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rready(m0_rready), .m0_rvalid(a_m0_rvalid), .m0_raddr(m0_raddr),
    .m0_rresp(a_m0_rresp), .m0_rdata(a_m0_rdata),
    .m1_wready(m1_wready), .m1_wvalid(a_m1_wvalid), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rready(m1_rready), .m1_rvalid(a_m1_rvalid), .m1_raddr(m1_raddr),
    .m1_rresp(a_m1_rresp), .m1_rdata(a_m1_rdata),
    .s_wready(a_s_wready), .s_waddr(a_s_waddr), .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb),
    .s_wvalid(s_wvalid), .s_rready(a_s_rready), .s_raddr(a_s_raddr), .s_rvalid(s_rvalid),
    .s_rresp(s_rresp), .s_rdata(s_rdata)
  );

  clint_arbiter #(.PRIO_M0(1'b1)) dut_b (
    .clk(clk), .resetb(resetb),
`ifdef CLINT_ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .m0_wready(m0_wready), .m0_wvalid(b_m0_wvalid), .m0_waddr(m0_waddr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rready(m0_rready), .m0_rvalid(b_m0_rvalid), .m0_raddr(m0_raddr),
    .m0_rresp(b_m0_rresp), .m0_rdata(b_m0_rdata),
    .m1_wready(m1_wready), .m1_wvalid(b_m1_wvalid), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rready(m1_rready), .m1_rvalid(b_m1_rvalid), .m1_raddr(m1_raddr),
    .m1_rresp(b_m1_rresp), .m1_rdata(b_m1_rdata),
    .s_wready(b_s_wready), .s_waddr(b_s_waddr), .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb),
    .s_wvalid(s_wvalid), .s_rready(b_s_rready), .s_raddr(b_s_raddr), .s_rvalid(s_rvalid),
    .s_rresp(s_rresp), .s_rdata(s_rdata)
  );

  wexp_t wq[$];
  rexp_t rq[$];
  logic  pq[$];
  int    errors = 0;
  int    checks = 0;
  bit    chk_p = 1'b0;
  int    dcnt = 0;

  function automatic logic [31:0] clint_val(input logic [31:0] a);
    if (a == MTIME_BASE) return MTIME_LO;
    if (a == MSIP_BASE)  return MSIP_WORD;
    return 32'hCAFE_0000 | a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CLINT model: accepts at once, answers one cycle after a read accept of dut_a.
  always @(posedge clk) begin
    s_rresp <= a_s_rready & s_rvalid;
    s_rdata <= clint_val(a_s_raddr);
  end

  wexp_t we;
  rexp_t re;
  logic  pe;
  always @(negedge clk) begin
    if (resetb) begin
      if (a_m0_wvalid || a_m1_wvalid) begin
        if (wq.size() == 0) begin
          chk("stray_write", {a_m1_wvalid, a_m0_wvalid}, 2'b00);
        end else begin
          we = wq.pop_front();
          chk("w_grant", {a_m1_wvalid, a_m0_wvalid}, id2gnt(we.id));
          chk("w_addr", a_s_waddr, we.addr);
          chk("w_data", a_s_wdata, we.data);
          chk("w_strb", a_s_wstrb, we.strb);
          $display("write  m%0d addr=%0h data=%0h", a_m1_wvalid, a_s_waddr, a_s_wdata);
        end
      end
      if (a_m0_rresp || a_m1_rresp) begin
        chk("rresp_excl", a_m0_rresp & a_m1_rresp, 1'b0);
        if (rq.size() == 0) begin
          chk("stray_rresp", {a_m1_rresp, a_m0_rresp}, 2'b00);
        end else begin
          re = rq.pop_front();
          chk("r_owner", {a_m1_rresp, a_m0_rresp}, id2gnt(re.id));
          chk("r_data", re.id ? a_m1_rdata : a_m0_rdata, re.data);
          $display("rresp  m%0d data=%0h", a_m1_rresp, a_m0_rdata);
        end
      end
      if (chk_p && (b_m0_rvalid || b_m1_rvalid)) begin
        if (pq.size() == 0) begin
          chk("stray_prio_read", {b_m1_rvalid, b_m0_rvalid}, 2'b00);
        end else begin
          pe = pq.pop_front();
          chk("prio_grant", {b_m1_rvalid, b_m0_rvalid}, id2gnt(pe));
          $display("prio   m%0d read accepted", b_m1_rvalid);
        end
      end
    end
  end

  // One cycle of stimulus; ew/er/ep are the hand-derived winners (-1 = none expected).
  task automatic step(input bit w0, input bit w1, input bit r0, input bit r1,
                      input int ew, input int er, input int ep);
    wexp_t w;
    rexp_t r;
    m0_wready = w0; m1_wready = w1; m0_rready = r0; m1_rready = r1;
    m0_wdata = 32'hA000_0000 + 32'(dcnt);
    m1_wdata = 32'hB000_0000 + 32'(dcnt);
    dcnt++;
    if (ew >= 0) begin
      w.id   = (ew == 1);
      w.addr = w.id ? m1_waddr : m0_waddr;
      w.data = w.id ? m1_wdata : m0_wdata;
      w.strb = w.id ? m1_wstrb : m0_wstrb;
      wq.push_back(w);
    end
    if (er >= 0) begin
      r.id   = (er == 1);
      r.data = clint_val(r.id ? m1_raddr : m0_raddr);
      rq.push_back(r);
    end
    if (ep >= 0) pq.push_back(ep == 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1);
  endtask

  task automatic do_reset();
    m0_wready = 0; m1_wready = 0; m0_rready = 0; m1_rready = 0;
    m0_lock = 0; m1_lock = 0;
    resetb = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_outputs", {a_m0_wvalid, a_m1_wvalid, a_m0_rvalid, a_m1_rvalid, a_m0_rresp, a_m1_rresp}, 6'b0);
    chk("rst_slave_req", {a_s_wready, a_s_rready}, 2'b00);
    resetb = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m0_waddr = MTIMECMP_BASE;
    m1_waddr = MTIMECMP_BASE + 32'h4;
    do_reset();

    // Single writer
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, -1, -1);
    idle();

    // Contended writes alternate
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b0, 1'b0, k % 2, -1, -1);
    idle();

    // Contended reads: rr on dut_a, m0 always on dut_b
    do_reset();
    m0_raddr = MSIP_BASE;
    m1_raddr = MTIME_BASE;
    chk_p = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b1, -1, k % 2, 0);
    idle();
    chk_p = 1'b0;

    // Back-to-back reads from different masters
    step(1'b0, 1'b0, 1'b0, 1'b1, -1, 1, -1);
    step(1'b0, 1'b0, 1'b1, 1'b0, -1, 0, -1);
    idle();
    idle();

`ifdef CLINT_ARB_LOCK_EN
    do_reset();
    m1_lock = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1, -1, -1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1, -1, -1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1, -1, -1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1, -1, -1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, -1, -1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1, -1, -1);
    m1_lock = 1'b0;
    idle();
`endif

    // Reset while a read response is pending
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, -1, -1, -1);
    m0_rready = 1'b0;
    resetb = 1'b0;
    #1;
    chk("rst_drop_rresp", {a_m1_rresp, a_m0_rresp}, 2'b00);
    @(posedge clk);
    #1;
    resetb = 1'b1;
    chk("post_rst_rresp", {a_m1_rresp, a_m0_rresp}, 2'b00);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, -1, -1);
    idle();
    idle();

    chk("wq_drained", 64'(wq.size()), 64'd0);
    chk("rq_drained", 64'(rq.size()), 64'd0);
    chk("pq_drained", 64'(pq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
